game_monitor: RTL

GAME_MONITOR -- requirements
Module: game_monitor

---
 rtl/game_pkg.sv | 33 +++
 rtl/sat_counter.sv | 26 ++
 rtl/game_monitor.sv | 132 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types for the game result monitor: board cell values, result codes
// and the monitor FSM state encoding.
package game_pkg;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] X     = 2'd1;
    localparam logic [1:0] O     = 2'd2;

    typedef enum logic [1:0] {
        ABANDON = 2'd0,
        XWIN    = 2'd1,
        OWIN    = 2'd2,
        TIE     = 2'd3
    } res_code_e;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        REPORT = 2'd1,
        HOLD   = 2'd2
    } state_e;

    // A single clear winner gets its code; both or neither counts as a tie.
    function automatic res_code_e classify(input logic win_x, input logic win_o);
        if (win_x && !win_o) begin
            return XWIN;
        end else if (win_o && !win_x) begin
            return OWIN;
        end else begin
            return TIE;
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for every tally of the game monitor.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count up on inc, sticking at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count <= {W{1'b0}};
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/game_monitor.sv
// Watches the game stage, offers one result per game over a valid/ready
// handshake and keeps tallies. Optional abandon timeout: GAME_MONITOR_TIMEOUT_EN.
module game_monitor
    import game_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             winX,
    input  logic             winO,
    input  logic             finished,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [1:0]       res_code,
    output logic [CNT_W-1:0] x_wins,
    output logic [CNT_W-1:0] o_wins,
    output logic [CNT_W-1:0] ties,
    output logic [CNT_W-1:0] games,
    output logic             error
);

    state_e    r_state;
    res_code_e r_code;
    logic      r_valid;
    logic      r_error;
    logic      w_viol;
    logic      w_enter;
    res_code_e w_new_code;

`ifdef GAME_MONITOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_timer;

    // Cycles spent in PLAY without a result; cleared whenever PLAY is left.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_timer <= {TW{1'b0}};
        end else if ((r_state == PLAY) && !w_enter) begin
            r_timer <= r_timer + TW'(1);
        end else begin
            r_timer <= {TW{1'b0}};
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
`endif

    // Decide whether this edge starts a report and with which code.
    always_comb begin
        w_viol     = (winX & winO) | ((winX | winO) & ~finished);
        w_enter    = 1'b0;
        w_new_code = ABANDON;
        if ((r_state == PLAY) && finished) begin
            w_enter    = 1'b1;
            w_new_code = classify(winX, winO);
        end
`ifdef GAME_MONITOR_TIMEOUT_EN
        else if ((r_state == PLAY) && (r_timer == TW'(TIMEOUT - 1))) begin
            w_enter    = 1'b1;
            w_new_code = ABANDON;
        end
`endif
        else begin
            w_enter    = 1'b0;
            w_new_code = ABANDON;
        end
    end

    // Result FSM with registered valid/code and sticky protocol error.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= PLAY;
            r_valid <= 1'b0;
            r_code  <= ABANDON;
            r_error <= 1'b0;
        end else begin
            r_error <= r_error | w_viol;
            case (r_state)
                PLAY: begin
                    if (w_enter) begin
                        r_state <= REPORT;
                        r_valid <= 1'b1;
                        r_code  <= w_new_code;
                    end else begin
                        r_state <= PLAY;
                        r_valid <= 1'b0;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        r_state <= HOLD;
                        r_valid <= 1'b0;
                    end else begin
                        r_state <= REPORT;
                        r_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    r_valid <= 1'b0;
                    if (!finished) begin
                        r_state <= PLAY;
                    end else begin
                        r_state <= HOLD;
                    end
                end
                default: begin
                    r_state <= PLAY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Tallies bump on the same edge that enters REPORT.
    logic w_inc_x, w_inc_o, w_inc_t;
    assign w_inc_x = w_enter && (w_new_code == XWIN);
    assign w_inc_o = w_enter && (w_new_code == OWIN);
    assign w_inc_t = w_enter && (w_new_code == TIE);

    sat_counter #(.W(CNT_W)) u_x_wins (.clock(clock), .reset_n(reset_n), .inc(w_inc_x), .count(x_wins));
    sat_counter #(.W(CNT_W)) u_o_wins (.clock(clock), .reset_n(reset_n), .inc(w_inc_o), .count(o_wins));
    sat_counter #(.W(CNT_W)) u_ties   (.clock(clock), .reset_n(reset_n), .inc(w_inc_t), .count(ties));
    sat_counter #(.W(CNT_W)) u_games  (.clock(clock), .reset_n(reset_n), .inc(w_enter), .count(games));

    assign res_valid = r_valid;
    assign res_code  = r_code;
    assign error     = r_error;

endmodule
